// File: rtl/lanes_seq.sv
// lanes_seq: sequences vector operations over a register file in 4x32-bit groups.
// Each group is read, handed to external lanes, waited on for the lane latency
// and then written back, one group at a time.
module lanes_seq #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned LAT_INT = 2,
    parameter int unsigned LAT_FP  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        func,
    input  logic [ADDR_W-1:0] src_a_base,
    input  logic [ADDR_W-1:0] src_b_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [127:0]      rd_data_a,
    input  logic [127:0]      rd_data_b,
    output logic [127:0]      lane_a,
    output logic [127:0]      lane_b,
    output logic [1:0]        lane_func,
    input  logic [127:0]      lane_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_data
);

    localparam int unsigned LAT_MAX = (LAT_FP > LAT_INT) ? LAT_FP : LAT_INT;
    localparam int unsigned CNT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]  wait_q;
    logic              last_group;
    logic [CNT_W-1:0]  lat_sel;

    // Address generation wraps naturally at ADDR_W bits.
    assign rd_addr_a = src_a_q + idx_q;
    assign rd_addr_b = src_b_q + idx_q;
    assign wr_addr   = dst_q + idx_q;
    assign wr_data   = lane_result;

    // idx is one narrower than count, so widen it before comparing with count-1.
    assign last_group = (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == count_q);
    assign lat_sel    = lane_func[0] ? CNT_W'(LAT_FP) : CNT_W'(LAT_INT);

    // Sequencer: state, operand capture, latency countdown and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            lane_a    <= '0;
            lane_b    <= '0;
            lane_func <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        lane_func <= func;
                        src_a_q   <= src_a_base;
                        src_b_q   <= src_b_base;
                        dst_q     <= dst_base;
                        count_q   <= count;
                        idx_q     <= '0;
                        if (count != '0) begin
                            state_q <= StRead;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    lane_a  <= rd_data_a;
                    lane_b  <= rd_data_b;
                    wait_q  <= lat_sel;
                    state_q <= StWait;
                end
                StWait: begin
                    // A zero latency is treated as a single wait cycle.
                    if (wait_q <= CNT_W'(1)) begin
                        wait_q  <= '0;
                        wr_en   <= 1'b1;
                        state_q <= StWrite;
                    end else begin
                        wait_q <= wait_q - CNT_W'(1);
                    end
                end
                StWrite: begin
                    wr_en <= 1'b0;
                    if (last_group) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        state_q <= StRead;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    wr_en   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/lanes_seq.md
LANES_SEQ -- requirements
Module: lanes_seq

Interface
REQ-001 Parameter ADDR_W, default 4: vector register file address width, in groups of 4x32-bit elements.
REQ-002 Parameter LAT_INT, default 2: lane latency in cycles for integer functions (func[0]=0).
REQ-003 Parameter LAT_FP, default 16: lane latency in cycles for floating-point functions (func[0]=1).
REQ-004 clk  in  1: sole clock; all state changes on its rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: request a vector operation; sampled only in IDLE.
REQ-007 func  in  2: lane function code, forwarded unchanged to the lanes.
REQ-008 src_a_base, src_b_base, dst_base  in  ADDR_W each: first group address of operand A, operand B and destination.
REQ-009 count  in  ADDR_W+1: number of 4-element groups to process, 0..2^ADDR_W.
REQ-010 busy  out  1: high while an operation is in progress.
REQ-011 done  out  1: one-cycle completion pulse.
REQ-012 rd_addr_a, rd_addr_b  out  ADDR_W: register file read addresses.
REQ-013 rd_data_a, rd_data_b  in  128: combinational read data; element i is bits [32i+31:32i].
REQ-014 lane_a, lane_b  out  128 (registered): operands to lanes 0..3.
REQ-015 lane_func  out  2 (registered): function code to the lanes.
REQ-016 lane_result  in  128: results from lanes 0..3.
REQ-017 wr_en  out  1, wr_addr  out  ADDR_W, wr_data  out  128: register file write port.

Function
REQ-018 The block SHALL implement the states IDLE, READ, WAIT, WRITE and DONE.
REQ-019 In IDLE, start=1 SHALL latch func, all three bases and count, and clear the group index idx.
- If the latched count is nonzero, the next state SHALL be READ.
- If the latched count is 0, the next state SHALL be DONE, with no reads or writes.
REQ-020 In READ, rd_addr_a SHALL equal (src_a_base+idx) mod 2^ADDR_W, and rd_addr_b SHALL equal (src_b_base+idx) mod 2^ADDR_W.
REQ-021 At the edge leaving READ, lane_a/lane_b SHALL load rd_data_a/rd_data_b, the wait counter SHALL load LAT_FP if func[0]=1 (else LAT_INT), and the next state SHALL be WAIT.
REQ-022 WAIT SHALL last exactly the loaded latency in cycles; lane_a, lane_b and lane_func SHALL stay constant throughout.
REQ-023 WRITE SHALL last one cycle with:
- wr_en=1
- wr_addr=(dst_base+idx) mod 2^ADDR_W
- wr_data=lane_result sampled in that cycle
REQ-024 After WRITE, if idx=count-1 the next state SHALL be DONE; otherwise idx SHALL increment and the next state SHALL be READ.
REQ-025 Each group SHALL take exactly LAT+2 cycles; N groups SHALL take N*(LAT+2) cycles from the first READ to the last WRITE.
REQ-026 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-027 A new start SHALL be accepted no earlier than the cycle after DONE.
REQ-028 busy SHALL be 1 in READ, WAIT and WRITE, and 0 in IDLE and DONE.
REQ-029 start asserted while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-030 Changes on func, bases or count after acceptance SHALL NOT affect the operation in progress.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W; count=2^ADDR_W SHALL process every address exactly once.
REQ-032 wr_en SHALL be 0 in every state other than WRITE.
REQ-033 rd_addr_a/rd_addr_b SHALL be don't-care outside READ.

Reset
REQ-034 While rst=1, regardless of clk, the block SHALL hold:
- state=IDLE, idx=0, wait counter=0
- busy=0, done=0, wr_en=0
- lane_a=0, lane_b=0, lane_func=0
REQ-035 Reset mid-operation SHALL abort immediately, with no further write and no done pulse.
REQ-036 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-037 Integer operation: count=1, func=00, src_a_base=0, src_b_base=1, dst_base=2, mem[0]={74,32,333,32}, mem[1]={12,41,12,63}, lane model = add with LAT_INT=2.
- Expected: exactly one write, to addr 2, of {86,73,345,95}.
- Expected: first READ to WRITE is 4 cycles; done 1 cycle later.
REQ-038 FP operation: count=3, func=01, LAT_FP=16.
- Expected: writes at addresses dst_base, +1, +2, spaced exactly 18 cycles apart.
- Expected: lane_a/lane_b are stable during every WAIT; done is a single pulse.
REQ-039 Wrap-around: count=3, dst_base=15, src_a_base=14, ADDR_W=4.
- Expected: reads A at 14, 15, 0.
- Expected: writes at 15, 0, 1.
REQ-040 count=0 with start=1.
- Expected: done=1 exactly 1 cycle after acceptance.
- Expected: busy stays 0 and wr_en never asserts.
REQ-041 Start while busy: start is pulsed during WAIT of a count=2 operation.
- Expected: it is ignored, exactly 2 writes occur, and only one done pulse.
REQ-042 Reset mid-WAIT: rst is asserted asynchronously between clock edges.
- Expected: busy/wr_en/lane_a go to 0 before the next edge, with no later write or done.
- Expected: after release, a new count=1 start completes normally.
